// File: rtl/intr_ctrl.sv
// +-----------------------------------------------------------------------------+
// | intr_ctrl: edge-latched, masked, fixed-priority interrupt controller with     |
// | IRQ/ack/EOI handshake to the CPU. Revision: 1.0                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module intr_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int VEC_W   = 3
) (
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic [NUM_SRC-1:0] I_src,
  input  logic               I_mask_we,
  input  logic [NUM_SRC-1:0] I_mask_wdata,
  input  logic               I_ovr_clr,
  input  logic               I_ack,
  input  logic               I_eoi,
  output logic               O_irq,
  output logic [VEC_W-1:0]   O_vector,
  output logic               O_active,
  output logic [NUM_SRC-1:0] O_pending,
  output logic [NUM_SRC-1:0] O_mask,
  output logic [NUM_SRC-1:0] O_overrun
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_SRC-1:0] r_src_q;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_overrun;
  logic               r_irq;
  logic [VEC_W-1:0]   r_vector;
  logic               r_active;

  logic [NUM_SRC-1:0] w_edge;
  logic [NUM_SRC-1:0] w_req;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_ovr_set;
  logic [VEC_W-1:0]   w_win_idx;
  logic               w_irq_nxt;
  logic               w_active_nxt;
  logic [VEC_W-1:0]   w_vector_nxt;

  assign w_edge    = I_src & ~r_src_q;
  assign w_req     = r_pending & r_mask;
  // A fresh edge on a bit being acknowledged this cycle is a new event, not a lost one.
  assign w_ovr_set = w_edge & r_pending & ~w_clr;

  always_comb begin
    w_win_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_win_idx = VEC_W'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_irq_nxt    = r_irq;
    w_active_nxt = r_active;
    w_vector_nxt = r_vector;
    w_clr        = '0;
    case (r_state)
      S_IDLE: begin
        if (|w_req) begin
          w_state_nxt  = S_ASSERT;
          w_irq_nxt    = 1'b1;
          w_vector_nxt = w_win_idx;
        end
      end
      S_ASSERT: begin
        if (I_ack) begin
          w_state_nxt  = S_SERVICE;
          w_irq_nxt    = 1'b0;
          w_active_nxt = 1'b1;
          w_clr        = NUM_SRC'(1) << r_vector;
        end
      end
      S_SERVICE: begin
        if (I_eoi) begin
          w_state_nxt  = S_IDLE;
          w_active_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_irq_nxt    = 1'b0;
        w_active_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge I_clk) begin
    // Tracks the lines through reset so a level already high at release is not an event.
    r_src_q <= I_src;
    if (I_rst) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_mask    <= '0;
      r_overrun <= '0;
      r_irq     <= 1'b0;
      r_vector  <= '0;
      r_active  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= (r_pending & ~w_clr) | w_edge;
      r_overrun <= (I_ovr_clr ? '0 : r_overrun) | w_ovr_set;
      r_irq     <= w_irq_nxt;
      r_vector  <= w_vector_nxt;
      r_active  <= w_active_nxt;
      if (I_mask_we) begin
        r_mask <= I_mask_wdata;
      end
    end
  end

  assign O_irq     = r_irq;
  assign O_vector  = r_vector;
  assign O_active  = r_active;
  assign O_pending = r_pending;
  assign O_mask    = r_mask;
  assign O_overrun = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_intr_ctrl.sv
// Directed, table-driven bench for intr_ctrl; each record is one clock edge of stimulus
// and the outputs expected right after that edge.
`default_nettype none

module tb_intr_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] src;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       ovr_clr;
  logic       ack;
  logic       eoi;
  logic       irq;
  logic [2:0] vector;
  logic       active;
  logic [7:0] pending;
  logic [7:0] mask;
  logic [7:0] overrun;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  intr_ctrl #(.NUM_SRC(8), .VEC_W(3)) dut (
    .I_clk(clk), .I_rst(rst), .I_src(src), .I_mask_we(mask_we),
    .I_mask_wdata(mask_wdata), .I_ovr_clr(ovr_clr), .I_ack(ack), .I_eoi(eoi),
    .O_irq(irq), .O_vector(vector), .O_active(active), .O_pending(pending),
    .O_mask(mask), .O_overrun(overrun)
  );

  typedef struct {
    logic [7:0] src;
    logic       we;
    logic [7:0] wd;
    logic       oc;
    logic       ack;
    logic       eoi;
    logic       rst;
    logic       irq;
    logic [2:0] vec;
    logic       act;
    logic [7:0] pend;
    logic [7:0] mask;
    logic [7:0] ovr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [7:0] s, input logic w, input logic [7:0] d,
                             input logic o, input logic a, input logic e, input logic r,
                             input logic xi, input logic [2:0] xv, input logic xa,
                             input logic [7:0] xp, input logic [7:0] xm, input logic [7:0] xo);
    vec_t t;
    t.src = s; t.we = w; t.wd = d; t.oc = o; t.ack = a; t.eoi = e; t.rst = r;
    t.irq = xi; t.vec = xv; t.act = xa; t.pend = xp; t.mask = xm; t.ovr = xo;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] s, input logic w, input logic [7:0] d,
                       input logic o, input logic a, input logic e, input logic r);
    src = s; mask_we = w; mask_wdata = d; ovr_clr = o; ack = a; eoi = e; rst = r;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  initial begin
    drive(8'h00, 0, 8'h00, 0, 0, 0, 1);
    repeat (3) tick();

    //        src  we wd   oc ack eoi rst   irq vec act pend  mask  ovr
    tbl.push_back(v(8'h00,0,8'h00,0,0,0,1, 0,0,0,8'h00,8'h00,8'h00)); // 0 reset
    tbl.push_back(v(8'h00,1,8'hFF,0,0,0,0, 0,0,0,8'h00,8'hFF,8'h00));
    tbl.push_back(v(8'h08,0,8'h00,0,0,0,0, 0,0,0,8'h08,8'hFF,8'h00));
    tbl.push_back(v(8'h00,0,8'h00,0,0,0,0, 1,3,0,8'h08,8'hFF,8'h00)); // 2-cycle latency
    tbl.push_back(v(8'h00,0,8'h00,0,0,0,0, 1,3,0,8'h08,8'hFF,8'h00));
    tbl.push_back(v(8'h00,0,8'h00,0,1,0,0, 0,3,1,8'h00,8'hFF,8'h00)); // 5 ack
    tbl.push_back(v(8'h00,0,8'h00,0,0,1,0, 0,3,0,8'h00,8'hFF,8'h00));
    tbl.push_back(v(8'h00,0,8'h00,0,0,0,0, 0,3,0,8'h00,8'hFF,8'h00));
    tbl.push_back(v(8'h24,0,8'h00,0,0,0,0, 0,3,0,8'h24,8'hFF,8'h00)); // 8 src 5+2
    tbl.push_back(v(8'h00,0,8'h00,0,0,0,0, 1,2,0,8'h24,8'hFF,8'h00));
    tbl.push_back(v(8'h00,0,8'h00,0,1,0,0, 0,2,1,8'h20,8'hFF,8'h00));
    tbl.push_back(v(8'h00,0,8'h00,0,0,1,0, 0,2,0,8'h20,8'hFF,8'h00));
    tbl.push_back(v(8'h00,0,8'h00,0,0,0,0, 1,5,0,8'h20,8'hFF,8'h00));
    tbl.push_back(v(8'h00,0,8'h00,0,1,0,0, 0,5,1,8'h00,8'hFF,8'h00));
    tbl.push_back(v(8'h00,0,8'h00,0,0,1,0, 0,5,0,8'h00,8'hFF,8'h00));
    tbl.push_back(v(8'h00,1,8'h00,0,0,0,0, 0,5,0,8'h00,8'h00,8'h00)); // 15 mask off
    tbl.push_back(v(8'h02,0,8'h00,0,0,0,0, 0,5,0,8'h02,8'h00,8'h00));
    tbl.push_back(v(8'h00,0,8'h00,0,0,0,0, 0,5,0,8'h02,8'h00,8'h00));
    tbl.push_back(v(8'h00,1,8'h02,0,0,0,0, 0,5,0,8'h02,8'h02,8'h00));
    tbl.push_back(v(8'h00,0,8'h00,0,0,0,0, 1,1,0,8'h02,8'h02,8'h00));
    tbl.push_back(v(8'h00,0,8'h00,0,1,0,0, 0,1,1,8'h00,8'h02,8'h00)); // 20
    tbl.push_back(v(8'h00,0,8'h00,0,0,1,0, 0,1,0,8'h00,8'h02,8'h00));
    tbl.push_back(v(8'h00,1,8'hFF,0,0,0,0, 0,1,0,8'h00,8'hFF,8'h00));
    tbl.push_back(v(8'h10,0,8'h00,0,0,0,0, 0,1,0,8'h10,8'hFF,8'h00)); // 23 overrun
    tbl.push_back(v(8'h00,0,8'h00,0,0,0,0, 1,4,0,8'h10,8'hFF,8'h00));
    tbl.push_back(v(8'h10,0,8'h00,0,0,0,0, 1,4,0,8'h10,8'hFF,8'h10));
    tbl.push_back(v(8'h00,0,8'h00,0,0,0,0, 1,4,0,8'h10,8'hFF,8'h10));
    tbl.push_back(v(8'h00,0,8'h00,1,0,0,0, 1,4,0,8'h10,8'hFF,8'h00));
    tbl.push_back(v(8'h10,0,8'h00,0,1,0,0, 0,4,1,8'h10,8'hFF,8'h00)); // 28 set beats clr
    tbl.push_back(v(8'h00,0,8'h00,0,0,1,0, 0,4,0,8'h10,8'hFF,8'h00));
    tbl.push_back(v(8'h00,0,8'h00,0,0,0,0, 1,4,0,8'h10,8'hFF,8'h00)); // 30
    tbl.push_back(v(8'h00,0,8'h00,0,1,0,0, 0,4,1,8'h00,8'hFF,8'h00));
    tbl.push_back(v(8'h10,0,8'h00,0,0,0,0, 0,4,1,8'h10,8'hFF,8'h00));
    tbl.push_back(v(8'h00,0,8'h00,0,0,0,0, 0,4,1,8'h10,8'hFF,8'h00));
    tbl.push_back(v(8'h10,0,8'h00,1,0,0,0, 0,4,1,8'h10,8'hFF,8'h10)); // 34 ovr set beats clr
    tbl.push_back(v(8'h00,0,8'h00,1,0,0,0, 0,4,1,8'h10,8'hFF,8'h00));
    tbl.push_back(v(8'h00,0,8'h00,0,0,1,0, 0,4,0,8'h10,8'hFF,8'h00));
    tbl.push_back(v(8'h00,0,8'h00,0,0,0,0, 1,4,0,8'h10,8'hFF,8'h00));
    tbl.push_back(v(8'h00,0,8'h00,0,0,1,0, 1,4,0,8'h10,8'hFF,8'h00)); // 38 eoi in ASSERT
    tbl.push_back(v(8'h00,0,8'h00,0,1,1,0, 0,4,1,8'h00,8'hFF,8'h00)); // ack+eoi = ack
    tbl.push_back(v(8'h00,0,8'h00,0,1,0,0, 0,4,1,8'h00,8'hFF,8'h00)); // 40 ack in SERVICE
    tbl.push_back(v(8'h00,0,8'h00,0,0,1,0, 0,4,0,8'h00,8'hFF,8'h00));
    tbl.push_back(v(8'h20,0,8'h00,0,0,0,0, 0,4,0,8'h20,8'hFF,8'h00)); // 42 commitment
    tbl.push_back(v(8'h00,0,8'h00,0,0,0,0, 1,5,0,8'h20,8'hFF,8'h00));
    tbl.push_back(v(8'h01,0,8'h00,0,0,0,0, 1,5,0,8'h21,8'hFF,8'h00));
    tbl.push_back(v(8'h00,1,8'h00,0,0,0,0, 1,5,0,8'h21,8'h00,8'h00));
    tbl.push_back(v(8'h00,0,8'h00,0,1,0,0, 0,5,1,8'h01,8'h00,8'h00));
    tbl.push_back(v(8'h00,0,8'h00,0,0,1,0, 0,5,0,8'h01,8'h00,8'h00));
    tbl.push_back(v(8'h00,1,8'hFF,0,0,0,0, 0,5,0,8'h01,8'hFF,8'h00));
    tbl.push_back(v(8'h00,0,8'h00,0,0,0,0, 1,0,0,8'h01,8'hFF,8'h00));
    tbl.push_back(v(8'h00,0,8'h00,0,1,0,0, 0,0,1,8'h00,8'hFF,8'h00)); // 50
    tbl.push_back(v(8'h00,0,8'h00,0,0,1,0, 0,0,0,8'h00,8'hFF,8'h00));
    tbl.push_back(v(8'h08,0,8'h00,0,0,0,0, 0,0,0,8'h08,8'hFF,8'h00)); // 52 event in SERVICE
    tbl.push_back(v(8'h00,0,8'h00,0,0,0,0, 1,3,0,8'h08,8'hFF,8'h00));
    tbl.push_back(v(8'h00,0,8'h00,0,1,0,0, 0,3,1,8'h00,8'hFF,8'h00));
    tbl.push_back(v(8'h40,0,8'h00,0,0,0,0, 0,3,1,8'h40,8'hFF,8'h00));
    tbl.push_back(v(8'h00,0,8'h00,0,0,0,0, 0,3,1,8'h40,8'hFF,8'h00));
    tbl.push_back(v(8'h00,0,8'h00,0,0,1,0, 0,3,0,8'h40,8'hFF,8'h00));
    tbl.push_back(v(8'h00,0,8'h00,0,0,0,0, 1,6,0,8'h40,8'hFF,8'h00));
    tbl.push_back(v(8'h51,0,8'h00,0,0,0,0, 1,6,0,8'h51,8'hFF,8'h40));
    tbl.push_back(v(8'h00,0,8'h00,0,0,0,1, 0,0,0,8'h00,8'h00,8'h00)); // 60 reset in ASSERT
    tbl.push_back(v(8'h00,0,8'h00,0,1,0,0, 0,0,0,8'h00,8'h00,8'h00)); // stray ack
    tbl.push_back(v(8'h00,1,8'hFF,0,0,0,0, 0,0,0,8'h00,8'hFF,8'h00));
    tbl.push_back(v(8'h00,0,8'h00,0,0,0,0, 0,0,0,8'h00,8'hFF,8'h00));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].src, tbl[i].we, tbl[i].wd, tbl[i].oc, tbl[i].ack, tbl[i].eoi, tbl[i].rst);
      tick();
      n_vec++;
      if (irq !== tbl[i].irq || vector !== tbl[i].vec || active !== tbl[i].act ||
          pending !== tbl[i].pend || mask !== tbl[i].mask || overrun !== tbl[i].ovr) begin
        n_fail++;
        $display("FAIL vec%0d: got irq=%b vec=%0d act=%b pend=%h mask=%h ovr=%h, expected irq=%b vec=%0d act=%b pend=%h mask=%h ovr=%h",
                 i, irq, vector, active, pending, mask, overrun,
                 tbl[i].irq, tbl[i].vec, tbl[i].act, tbl[i].pend, tbl[i].mask, tbl[i].ovr);
      end
    end

    // Line already high through reset must not register an event after release.
    drive(8'h01, 0, 8'h00, 0, 0, 0, 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(8'h01, 0, 8'h00, 0, 0, 0, 0);
      tick();
      chk("held_thru_rst_pend", 32'(pending), 32'h00);
    end
    drive(8'h00, 1, 8'hFF, 0, 0, 0, 0);
    tick();

    // Line held high for many cycles yields exactly one event.
    drive(8'h10, 0, 8'h00, 0, 0, 0, 0);
    tick();
    chk("held_first_pend", 32'(pending), 32'h10);
    begin
      int waited = 0;
      while (irq !== 1'b1 && waited < 5) begin
        tick();
        waited++;
      end
      chk("held_irq_seen", 32'(irq), 32'h1);
    end
    chk("held_vector", 32'(vector), 32'h4);
    drive(8'h10, 0, 8'h00, 0, 1, 0, 0);
    tick();
    drive(8'h10, 0, 8'h00, 0, 0, 1, 0);
    tick();
    drive(8'h10, 0, 8'h00, 0, 0, 0, 0);
    repeat (7) tick();
    chk("held_pend_after", 32'(pending), 32'h00);
    chk("held_ovr_after", 32'(overrun), 32'h00);
    chk("held_irq_after", 32'(irq), 32'h0);
    chk("held_act_after", 32'(active), 32'h0);
    drive(8'h00, 0, 8'h00, 0, 0, 0, 0);
    repeat (2) tick();
    chk("held_release_pend", 32'(pending), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
